// File: rtl/dp_seq_pkg.sv
// Shared types and sizing helpers for the round-robin datapath sequencer.
package dp_seq_pkg;

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  function automatic int unsigned id_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr, with wrap-around.
module rr_arbiter
  import dp_seq_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W = id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt_onehot,
  output logic [ID_W-1:0]    gnt_idx,
  output logic               any
);

  int unsigned idx;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    idx        = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(ptr) + i) % NUM_REQ;
      if (!any && req[idx]) begin
        any             = 1'b1;
        gnt_idx         = ID_W'(idx);
        gnt_onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/datapath_rr_sequencer.sv
// Shares one fixed-latency datapath among NUM_REQ requesters; one transaction in flight.
module datapath_rr_sequencer
  import dp_seq_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DP_LATENCY = 2,
  localparam int unsigned ID_W = id_w(NUM_REQ)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]       rsp_valid_o,
  input  logic [NUM_REQ-1:0]       rsp_ready_i,
  output logic [WIDTH-1:0]         rsp_data_o,
  output logic                     dp_enable_o,
  output logic [WIDTH-1:0]         dp_data_o,
  input  logic [WIDTH-1:0]         dp_data_i,
  output logic                     busy_o,
  output logic [ID_W-1:0]          grant_id_o
);

  state_t              state;
  logic [ID_W-1:0]     ptr;
  logic [CNT_W-1:0]    cnt;
  logic [NUM_REQ-1:0]  gnt_onehot;
  logic [ID_W-1:0]     gnt_idx;
  logic                gnt_any;
  logic [WIDTH-1:0]    sel_data;
  logic [ID_W-1:0]     ptr_next;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req        (req_valid_i),
    .ptr        (ptr),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (gnt_any)
  );

  // Ready is the only combinational output; gated by reset so it reads 0 while held in reset.
  assign req_ready_o = (state == ST_IDLE && rst_ni) ? gnt_onehot : '0;
  assign sel_data    = req_data_i[32'(gnt_idx)*WIDTH +: WIDTH];
  assign ptr_next    = (32'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      cnt         <= '0;
      rsp_valid_o <= '0;
      rsp_data_o  <= '0;
      dp_enable_o <= 1'b0;
      dp_data_o   <= '0;
      busy_o      <= 1'b0;
      grant_id_o  <= '0;
    end else begin
      dp_enable_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (gnt_any) begin
            dp_data_o   <= sel_data;
            grant_id_o  <= gnt_idx;
            ptr         <= ptr_next;
            dp_enable_o <= 1'b1;
            busy_o      <= 1'b1;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt   <= CNT_W'(DP_LATENCY - 1);
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            rsp_data_o  <= dp_data_i;
            rsp_valid_o <= NUM_REQ'(1) << grant_id_o;
            state       <= ST_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i[grant_id_o]) begin
            rsp_valid_o <= '0;
            busy_o      <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_datapath_rr_sequencer.sv
// Scoreboard bench: random requesters, queue of expected responses, latency-probe instances.
module tb_datapath_rr_sequencer;

  localparam int W = 8;
  localparam int N = 4;
  localparam int L = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic aux_rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*W-1:0] req_data;
  logic [W-1:0]   rsp_data, dp_out, dp_in;
  logic           dp_en, busy;
  logic [1:0]     gid;

  logic [1:0][N-1:0]   a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready;
  logic [1:0][N*W-1:0] a_req_data;
  logic [1:0][W-1:0]   a_rsp_data, a_dp_out;
  logic [1:0]          a_dp_en, a_busy;
  logic [1:0][1:0]     a_gid;
  logic [W-1:0]        cyc8;

  int cyc = 0;
  always @(negedge clk) cyc <= cyc + 1;
  assign cyc8 = W'(cyc);

  datapath_rr_sequencer #(.WIDTH(W), .NUM_REQ(N), .DP_LATENCY(L)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_data_i(req_data), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data), .dp_enable_o(dp_en), .dp_data_o(dp_out), .dp_data_i(dp_in),
    .busy_o(busy), .grant_id_o(gid)
  );

  datapath_rr_sequencer #(.WIDTH(W), .NUM_REQ(N), .DP_LATENCY(1)) dut_l1 (
    .clk_i(clk), .rst_ni(aux_rst_n), .req_valid_i(a_req_valid[0]), .req_ready_o(a_req_ready[0]),
    .req_data_i(a_req_data[0]), .rsp_valid_o(a_rsp_valid[0]), .rsp_ready_i(a_rsp_ready[0]),
    .rsp_data_o(a_rsp_data[0]), .dp_enable_o(a_dp_en[0]), .dp_data_o(a_dp_out[0]), .dp_data_i(cyc8),
    .busy_o(a_busy[0]), .grant_id_o(a_gid[0])
  );

  datapath_rr_sequencer #(.WIDTH(W), .NUM_REQ(N), .DP_LATENCY(255)) dut_l255 (
    .clk_i(clk), .rst_ni(aux_rst_n), .req_valid_i(a_req_valid[1]), .req_ready_o(a_req_ready[1]),
    .req_data_i(a_req_data[1]), .rsp_valid_o(a_rsp_valid[1]), .rsp_ready_i(a_rsp_ready[1]),
    .rsp_data_o(a_rsp_data[1]), .dp_enable_o(a_dp_en[1]), .dp_data_o(a_dp_out[1]), .dp_data_i(cyc8),
    .busy_o(a_busy[1]), .grant_id_o(a_gid[1])
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got timeout expected event (t=%0t)", name, $time);
  endtask

  typedef struct {
    int          id;
    logic [W-1:0] data;
    int          acc;
  } sb_t;

  sb_t  sbq[$];
  sb_t  cur;
  bit   have_cur = 0;
  bit   busy_m = 0;
  int   ptr_m = 0;
  int   acc_cyc = -10;
  logic [W-1:0] cur_op;
  int   n_acc = 0;
  int   n_rsp = 0;
  int   win_log[$];
  bit   space_on = 0;
  bit   prev_ok = 0;
  int   prev_acc = 0;
  logic [N-1:0] hs_prev = '0;

  // stimulus controls
  logic [N-1:0] req_en = '0;
  int   raise_pct = 0;
  int   rsp_pct = 100;
  bit   fix_on = 0;
  logic [W-1:0] fix_val = '0;
  bit   bp_on = 0;
  int   bp_cnt = 0;
  bit   aux_done = 0;

  // datapath model: result = operand + 1, valid only in the exact capture cycle
  bit   pend = 0;
  int   dcnt = 0;
  logic [W-1:0] dop = '0;

  // Monitor / scoreboard / datapath model (negedge)
  initial begin : monitor
    logic [N-1:0] hs;
    int win, c;
    dp_in = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sbq.delete();
        have_cur = 0; busy_m = 0; ptr_m = 0; pend = 0; hs_prev = '0;
        acc_cyc = -10; prev_ok = 0; dp_in = '0;
      end else begin
        chk("busy", 32'(busy), 32'(busy_m));
        chk("ready_any", 32'(|req_ready), 32'(!busy_m && (|req_valid)));
        chk("dp_enable", 32'(dp_en), 32'(busy_m && cyc == acc_cyc + 1));
        if (dp_en) chk("dp_operand", 32'(dp_out), 32'(cur_op));

        hs = req_ready & req_valid;
        hs_prev = hs;
        if (hs != '0) begin
          win = -1;
          for (int i = 0; i < N; i++) begin
            c = (ptr_m + i) % N;
            if (win < 0 && req_valid[c]) win = c;
          end
          chk("grant", 32'(hs), 32'(1) << win);
          cur_op = req_data[win*W +: W];
          sbq.push_back('{id: win, data: W'(cur_op + 1), acc: cyc});
          acc_cyc = cyc; busy_m = 1; ptr_m = (win + 1) % N; n_acc++;
          win_log.push_back(win);
          if (space_on) begin
            if (prev_ok) chk("b2b_spacing", 32'(cyc - prev_acc), 32'(L + 3));
            prev_acc = cyc; prev_ok = 1;
          end
        end

        if (rsp_valid != '0 && !have_cur) begin
          if (sbq.size() == 0) chk("unexpected_rsp", 32'(rsp_valid), 32'(0));
          else begin
            cur = sbq.pop_front(); have_cur = 1;
            chk("rsp_latency", 32'(cyc - cur.acc), 32'(L + 2));
          end
        end
        if (have_cur && rsp_valid == '0) chk("rsp_held", 32'(rsp_valid), 32'(1) << cur.id);
        if (have_cur && rsp_valid != '0) begin
          chk("rsp_valid", 32'(rsp_valid), 32'(1) << cur.id);
          chk("rsp_data", 32'(rsp_data), 32'(cur.data));
          if (rsp_ready[cur.id]) begin have_cur = 0; busy_m = 0; n_rsp++; end
        end

        if (dp_en) begin pend = 1; dcnt = L; dop = dp_out; end
        else if (pend) begin
          if (dcnt == 0) pend = 0;
          else dcnt--;
        end
        dp_in = (pend && dcnt == 0) ? W'(dop + 1) : W'(~(dop + 1));
      end
    end
  end

  // Requester / response-side driver (just after posedge)
  initial begin : driver
    req_valid = '0; req_data = '0; rsp_ready = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        req_valid = '0; rsp_ready = '0;
      end else begin
        for (int k = 0; k < N; k++) begin
          if (hs_prev[k]) req_valid[k] = 1'b0;
          if (!req_valid[k] && req_en[k] && $urandom_range(0, 99) < raise_pct) begin
            req_valid[k] = 1'b1;
            req_data[k*W +: W] = fix_on ? fix_val : W'($urandom);
          end
          rsp_ready[k] = ($urandom_range(0, 99) < rsp_pct);
        end
        if (bp_on) begin
          if (rsp_valid[1]) bp_cnt++;
          rsp_ready = 4'b1101 | ((bp_cnt > 10) ? 4'b0010 : 4'b0000);
        end
      end
    end
  end

  task automatic wait_acc(input int target, input int budget);
    int n = 0;
    while (n_acc < target && n < budget) begin @(negedge clk); #1; n++; end
    if (n_acc < target) fail_timeout("accept_timeout");
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((req_valid != '0 || busy_m || have_cur || sbq.size() != 0) && n < budget) begin
      @(negedge clk); #1; n++;
    end
    if (n >= budget) fail_timeout("drain_timeout");
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_dp_enable"}, 32'(dp_en), 0);
    chk({tag, "_dp_data"}, 32'(dp_out), 0);
    chk({tag, "_rsp_data"}, 32'(rsp_data), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_grant_id"}, 32'(gid), 0);
  endtask

  // Latency probes on DP_LATENCY=1 and 255: datapath input is the cycle counter,
  // so the captured value identifies the capture cycle.
  initial begin : aux
    int e, k, lat, n;
    logic [W-1:0] op;
    a_req_valid = '0; a_req_data = '0; a_rsp_ready = '1;
    #1 aux_rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 aux_rst_n = 1'b1;
    @(posedge clk); #1;
    for (int j = 0; j < 2; j++) begin
      for (int r = 0; r < 3; r++) begin
        lat = (j == 0) ? 1 : 255;
        k = $urandom_range(0, N - 1);
        op = W'($urandom);
        a_req_data[j][k*W +: W] = op;
        a_req_valid[j] = N'(1) << k;
        n = 0;
        while (!a_dp_en[j] && n < 20) begin @(posedge clk); #1; n++; end
        a_req_valid[j] = '0;
        if (!a_dp_en[j]) fail_timeout("aux_enable_timeout");
        else begin
          e = cyc;
          chk("aux_dp_operand", 32'(a_dp_out[j]), 32'(op));
          n = 0;
          while (a_rsp_valid[j] == '0 && n < 300) begin @(posedge clk); #1; n++; end
          chk("aux_rsp_valid", 32'(a_rsp_valid[j]), 32'(1) << k);
          chk("aux_capture_cycle", 32'(a_rsp_data[j]), 32'(W'(e + 1 + lat)));
          chk("aux_latency", 32'(n), 32'(lat + 1));
        end
        @(posedge clk); #1;
      end
    end
    aux_done = 1;
  end

  initial begin : main
    int base, n;
    #1 rst_n = 1'b0;
    #1 chk_zero("reset");
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // all four requesting continuously: round-robin, L+3 cycles apart
    prev_ok = 0; space_on = 1; rsp_pct = 100; raise_pct = 100; req_en = 4'hF;
    base = win_log.size();
    wait_acc(n_acc + 5, 60);
    space_on = 0; req_en = '0;
    drain(100);
    for (int i = 0; i < 5; i++)
      if (win_log.size() > base + i) chk("rr_order", 32'(win_log[base + i]), 32'(i % 4));

    // single request from requester 2 with operand 0x5A
    fix_on = 1; fix_val = 8'h5A; req_en = 4'b0100;
    wait_acc(n_acc + 1, 20);
    req_en = '0; fix_on = 0;
    drain(40);

    // backpressure on requester 1 while others wait
    req_en = 4'b0010;
    wait_acc(n_acc + 1, 20);
    bp_cnt = 0; bp_on = 1; req_en = 4'b1101;
    wait_acc(n_acc + 1, 60);
    req_en = '0;
    drain(100);
    bp_on = 0;

    // pointer wrap: only 3, then 0 and 3
    base = win_log.size();
    req_en = 4'b1000;
    wait_acc(n_acc + 1, 20);
    req_en = 4'b1001;
    wait_acc(n_acc + 2, 40);
    req_en = '0;
    drain(60);
    if (win_log.size() >= base + 3) begin
      chk("wrap_g0", 32'(win_log[base]), 3);
      chk("wrap_g1", 32'(win_log[base + 1]), 0);
      chk("wrap_g2", 32'(win_log[base + 2]), 3);
    end else fail_timeout("wrap_grants");

    // reset in the middle of a transaction
    req_en = 4'b0001;
    wait_acc(n_acc + 1, 20);
    req_en = '0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1 chk_zero("async_reset");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    base = win_log.size();
    req_en = 4'hF;
    wait_acc(n_acc + 1, 20);
    req_en = '0;
    if (win_log.size() > base) chk("post_reset_grant", 32'(win_log[base]), 0);
    drain(100);

    // random traffic
    raise_pct = 30; rsp_pct = 60; req_en = 4'hF;
    repeat (400) @(posedge clk);
    req_en = '0;
    drain(300);

    n = 0;
    while (!aux_done && n < 3000) begin @(posedge clk); n++; end
    if (!aux_done) fail_timeout("aux_timeout");
    chk("rsp_count", 32'(n_rsp), 32'(n_acc - 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
